fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO.
- Pops DSIZE-bit entries via the FIFO read interface (rd_empty/rd_inc/rd_data) and packs PACK consecutive entries into one output word.
- Output word is presented on a valid/ready stream; a flush request emits a final partial word with lane-keep bits.
- Lives entirely in the read clock domain.

Parameters:
- DSIZE, 8, width of one FIFO entry (one lane).
- PACK, 4, entries per output word; legal 2..16.
- CW, 5, counter width; must satisfy 2^CW > PACK.

Ports:
- rd_clk  input  1  read-domain clock; all logic rising-edge.
- rd_rst  input  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronised externally.
- rd_empty  input  1  FIFO empty flag.
- rd_data  input  DSIZE  FIFO read data; valid the cycle after rd_inc was high.
- rd_inc  output  1  FIFO pop strobe; one entry per high cycle.
- out_data  output  PACK*DSIZE  packed word; lane 0 (bits DSIZE-1:0) = oldest entry.
- out_keep  output  PACK  lane-valid mask; bit i covers lane i.
- out_valid  output  1  out_data/out_keep valid.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- flush  input  1  single-cycle request to emit any partial word.
- flush_done  output  1  one-cycle pulse when a flush completes.
- busy  output  1  high in any state other than FILL, or whenever cnt != 0 or an entry is in flight.

Behaviour:
- Reset (rd_rst = 0, async): rd_inc = 0, out_valid = 0, out_data = 0, out_keep = 0, flush_done = 0, busy = 0, cnt = 0, inflight = 0, state = FILL.
- Read latency: rd_inc high in cycle N means the entry is captured from rd_data in cycle N+1 (inflight flag set in N, cleared in N+1).
- Pop rule:
  - rd_inc = state==FILL && !rd_empty && (cnt + inflight < PACK) && !flush.
  - rd_inc is registered-free combinational from regs and inputs.
  - It is never high while rd_empty = 1.
- Capture: an arriving entry is written to lane cnt of the assembly register; cnt increments.
- Transfer: when cnt==PACK and (!out_valid || out_ready):
  - assembly moves to the output register with out_keep = all ones and out_valid = 1;
  - cnt clears to 0 and the assembly register clears.
- Output hold: out_data/out_keep remain stable while out_valid && !out_ready.
- Throughput with out_ready tied high and FIFO never empty: PACK entries per PACK+2 cycles.
- State machine (2-bit):
  - FILL:
    - normal packing.
    - flush=1 moves to FLUSH_WAIT; rd_inc is suppressed in that same cycle.
    - flush in any other state is ignored.
  - FLUSH_WAIT:
    - no pops; waits for inflight = 0 (the in-flight entry is still captured).
    - If cnt==PACK, the normal transfer happens first.
    - Then, if cnt==0, pulse flush_done and go to FILL.
    - Otherwise go to FLUSH_EMIT.
  - FLUSH_EMIT:
    - when !out_valid || out_ready, load the output register with the assembly contents.
    - out_keep = (1<<cnt)-1; unused lanes are zero.
    - cnt clears, flush_done pulses that cycle, and the state returns to FILL.
- Simultaneous events:
  - Transfer and capture never coincide, because the pop rule guarantees cnt==PACK implies inflight = 0.
  - Output accept and a new transfer in the same cycle: the new word loads and out_valid stays 1.
- Reset mid-operation discards partial data and any in-flight entry. The FIFO pop already issued is lost; this is accepted.
- Arithmetic: cnt + inflight is computed in CW bits with no overflow.

Test Plan:
- Reset with the FIFO holding 5 entries: during reset rd_inc = 0, out_valid = 0; after release, first rd_inc is in the cycle after rd_rst = 1.
- Stream entries 0x01..0x08, PACK=4, out_ready = 1:
  - out_data = 0x04030201, then 0x08070605, out_keep = 0xF each;
  - exactly 8 rd_inc pulses, 12 cycles from first rd_inc to second out_valid.
- Backpressure: out_ready = 0 for 20 cycles with 12 entries available.
  - First word holds stable; the second word is assembled; no more than 8 pops occur before out_ready rises.
  - Release: words 1, 2 and 3 emerge in order.
- Partial flush: push 0xAA, 0xBB, 0xCC, then flush = 1.
  - One word out_data = 0x00CCBBAA, out_keep = 0x7.
  - flush_done pulses once, and the state returns to FILL.
- Flush races an in-flight pop: flush in the cycle after the 2nd rd_inc.
  - Both entries are captured; out_keep = 0x3; no further pops until flush_done.
  - Flush with cnt = 0 gives flush_done with no output word.
- Empty FIFO (rd_empty = 1 throughout): rd_inc never asserts; async reset mid-word clears cnt; the next word starts at lane 0.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops DSIZE-bit entries and packs PACK of them into one
// valid/ready output word, with a flush path that emits a partial word plus lane-keep mask.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int PACK  = 4,
  parameter int CW    = 5
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_empty,
  input  logic [DSIZE-1:0]      rd_data,
  output logic                  rd_inc,
  output logic [PACK*DSIZE-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } state_t;

  localparam logic [CW-1:0] PACK_CNT = CW'(PACK);

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic                   inflight;
  logic [PACK*DSIZE-1:0]  assembly;
  logic [CW-1:0]          pending;
  logic [PACK-1:0]        part_keep;
  logic                   out_free;
  logic                   do_xfer;
  logic                   do_emit;
  logic                   done_nxt;

  // Entries already captured plus the one whose data arrives next cycle.
  assign pending  = cnt + {{(CW-1){1'b0}}, inflight};
  assign out_free = !out_valid || out_ready;
  assign do_xfer  = (cnt == PACK_CNT) && out_free;
  assign do_emit  = (state == FLUSH_EMIT) && out_free;

  assign rd_inc = rd_rst && (state == FILL) && !rd_empty && (pending < PACK_CNT) && !flush;
  assign busy   = (state != FILL) || (cnt != '0) || inflight;

  always_comb begin
    part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      part_keep[i] = (CW'(i) < cnt);
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      FILL: begin
        if (flush) state_nxt = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        // A full word drains through the normal transfer before the flush decision.
        if (!inflight && cnt != PACK_CNT) begin
          if (cnt == '0) begin
            done_nxt  = 1'b1;
            state_nxt = FILL;
          end else begin
            state_nxt = FLUSH_EMIT;
          end
        end
      end
      FLUSH_EMIT: begin
        if (out_free) begin
          done_nxt  = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) state <= FILL;
    else         state <= state_nxt;
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      cnt        <= '0;
      inflight   <= 1'b0;
      assembly   <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_valid  <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      inflight   <= rd_inc;
      flush_done <= done_nxt;
      if (out_valid && out_ready) out_valid <= 1'b0;
      // Transfer, emit and capture are mutually exclusive: a full or flushing word has nothing in flight.
      if (do_xfer) begin
        out_data  <= assembly;
        out_keep  <= '1;
        out_valid <= 1'b1;
        cnt       <= '0;
        assembly  <= '0;
      end else if (do_emit) begin
        out_data  <= assembly;
        out_keep  <= part_keep;
        out_valid <= 1'b1;
        cnt       <= '0;
        assembly  <= '0;
      end else if (inflight) begin
        for (int i = 0; i < PACK; i++) begin
          if (cnt == CW'(i)) assembly[i*DSIZE +: DSIZE] <= rd_data;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a small registered FIFO model feeds the DUT and
// accepted words, pops and flush_done pulses are logged at the clock edge.
module tb_fifo_rd_packer;

  logic        rd_clk;
  logic        rd_rst;
  logic        rd_empty;
  logic [7:0]  rd_data;
  logic        rd_inc;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        flush_done;
  logic        busy;

  logic [7:0]  mem [0:255];
  logic [7:0]  wr_ptr;
  logic [7:0]  rd_ptr;
  int          cyc;
  int          fd_cnt;
  int          assert_count;
  int          fail_count;

  logic [31:0] word_q [$];
  logic [3:0]  keep_q [$];
  int          word_cyc_q [$];
  int          pop_cyc_q [$];
  int          fd_pops_q [$];

  fifo_rd_packer #(.DSIZE(8), .PACK(4), .CW(5)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .rd_empty   (rd_empty),
    .rd_data    (rd_data),
    .rd_inc     (rd_inc),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  assign rd_empty = (rd_ptr == wr_ptr);

  // FIFO read port model plus edge logging of pops, accepted words and flush_done pulses.
  initial begin
    rd_ptr  = '0;
    rd_data = '0;
    cyc     = 0;
    fd_cnt  = 0;
  end

  always @(posedge rd_clk) begin
    if (flush_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_pops_q.push_back(pop_cyc_q.size());
    end
    if (rd_inc) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cyc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      word_q.push_back(out_data);
      keep_q.push_back(out_keep);
      word_cyc_q.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] entry);
    mem[wr_ptr] = entry;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
  endtask

  task automatic waitWords(input int n, input string tag);
    int budget;
    budget = 100;
    while (word_q.size() < n && budget > 0) begin
      @(negedge rd_clk);
      budget--;
    end
    checkOutput({tag, "_word_count"}, 64'(word_q.size()), 64'(n));
  endtask

  task automatic checkWord(input int idx, input logic [31:0] exp_data, input logic [3:0] exp_keep, input string tag);
    logic [31:0] d;
    logic [3:0]  k;
    d = (idx < word_q.size()) ? word_q[idx] : 32'hxxxx_xxxx;
    k = (idx < keep_q.size()) ? keep_q[idx] : 4'hx;
    checkOutput({tag, "_data"}, 64'(d), 64'(exp_data));
    checkOutput({tag, "_keep"}, 64'(k), 64'(exp_keep));
  endtask

  task automatic clearLogs();
    word_q.delete();
    keep_q.delete();
    word_cyc_q.delete();
    pop_cyc_q.delete();
    fd_pops_q.delete();
  endtask

  initial begin
    int   rel_cyc;
    int   first_pop;
    int   second_word;
    logic stable_ok;

    assert_count = 0;
    fail_count   = 0;
    wr_ptr       = '0;
    rd_rst       = 1'b0;
    out_ready    = 1'b1;
    flush        = 1'b0;

    // Reset with five entries waiting, then stream 0x01..0x08.
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    waitCycles(3);
    checkOutput("rst_rd_inc", 64'(rd_inc), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_keep", 64'(out_keep), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_flush_done", 64'(flush_done), 64'd0);
    checkOutput("rst_no_pops", 64'(pop_cyc_q.size()), 64'd0);
    rd_rst  = 1'b1;
    rel_cyc = cyc;
    #1;
    checkOutput("rel_rd_inc", 64'(rd_inc), 64'd1);
    for (int i = 6; i <= 8; i++) applyStimulus(8'(i));
    waitWords(2, "stream");
    waitCycles(4);
    checkWord(0, 32'h04030201, 4'hF, "stream_w0");
    checkWord(1, 32'h08070605, 4'hF, "stream_w1");
    checkOutput("stream_pops", 64'(pop_cyc_q.size()), 64'd8);
    first_pop   = (pop_cyc_q.size() > 0) ? pop_cyc_q[0] : -100;
    second_word = (word_cyc_q.size() > 1) ? word_cyc_q[1] : -100;
    checkOutput("first_pop_cycle", 64'(first_pop), 64'(rel_cyc));
    checkOutput("stream_latency", 64'(second_word - first_pop), 64'd12);
    checkOutput("stream_idle", 64'(busy), 64'd0);

    // Backpressure: sink stalls for 20 cycles with 12 entries available.
    clearLogs();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(8'h10 + 8'(i));
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      if (out_valid && out_data !== 32'h13121110) stable_ok = 1'b0;
      if (out_valid && out_keep !== 4'hF) stable_ok = 1'b0;
    end
    checkOutput("bp_hold_stable", 64'(stable_ok), 64'd1);
    checkOutput("bp_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_data", 64'(out_data), 64'h13121110);
    checkOutput("bp_pops", 64'(pop_cyc_q.size()), 64'd8);
    checkOutput("bp_busy", 64'(busy), 64'd1);
    checkOutput("bp_no_accept", 64'(word_q.size()), 64'd0);
    out_ready = 1'b1;
    waitWords(3, "bp_release");
    waitCycles(3);
    checkWord(0, 32'h13121110, 4'hF, "bp_w0");
    checkWord(1, 32'h17161514, 4'hF, "bp_w1");
    checkWord(2, 32'h1B1A1918, 4'hF, "bp_w2");
    checkOutput("bp_total_pops", 64'(pop_cyc_q.size()), 64'd12);

    // Partial flush of three entries.
    clearLogs();
    fd_cnt = 0;
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    waitCycles(6);
    pulseFlush();
    waitWords(1, "flush3");
    waitCycles(4);
    checkWord(0, 32'h00CCBBAA, 4'h7, "flush3_w0");
    checkOutput("flush3_done_pulses", 64'(fd_cnt), 64'd1);
    checkOutput("flush3_idle", 64'(busy), 64'd0);

    // Flush raised in the cycle after the second pop, with more entries waiting.
    clearLogs();
    fd_cnt = 0;
    for (int i = 0; i < 4; i++) applyStimulus(8'h31 + 8'(i));
    waitCycles(2);
    pulseFlush();
    waitWords(1, "race");
    waitCycles(1);
    checkWord(0, 32'h00003231, 4'h3, "race_w0");
    checkOutput("race_pops_at_done", 64'((fd_pops_q.size() > 0) ? fd_pops_q[0] : -1), 64'd2);
    waitCycles(8);
    checkOutput("race_resume_pops", 64'(pop_cyc_q.size()), 64'd4);
    pulseFlush();
    waitWords(2, "race_tail");
    waitCycles(4);
    checkWord(1, 32'h00003433, 4'h3, "race_w1");
    pulseFlush();
    waitCycles(5);
    checkOutput("empty_flush_done", 64'(fd_cnt), 64'd3);
    checkOutput("empty_flush_no_word", 64'(word_q.size()), 64'd2);

    // Reset mid-word, then an empty FIFO, then a fresh word must start at lane 0.
    clearLogs();
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    waitCycles(6);
    checkOutput("midword_busy", 64'(busy), 64'd1);
    rd_rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_rd_inc", 64'(rd_inc), 64'd0);
    waitCycles(3);
    rd_rst = 1'b1;
    waitCycles(10);
    checkOutput("empty_no_pops", 64'(pop_cyc_q.size()), 64'd2);
    checkOutput("empty_no_words", 64'(word_q.size()), 64'd0);
    checkOutput("empty_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(8'h51 + 8'(i));
    waitWords(1, "post_rst");
    checkWord(0, 32'h54535251, 4'hF, "post_rst_w0");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
